dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data RAM between the pipeline MEM stage (port 0) and the debug/program-loader port (port 1). It grants at most one access per cycle using round-robin with bounded loader burst locking, rejects out-of-segment accesses, drives the RAM's address/write-data/byte-strobe/write-enable inputs, and returns registered read data with a one-cycle response.

---
 rtl/dmem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-ported data RAM between the pipeline MEM stage (port 0)
// and the debug/program-loader port (port 1). At most one access is granted
// per cycle. Arbitration is round-robin, but port 1 may lock the RAM for a
// bounded run of back-to-back grants. Accesses outside the data segment are
// accepted and answered with an error, but never reach the RAM. Each port
// gets a registered response one cycle after its transfer.
//
// Parameters
//   DATA_SEG_BEGIN  byte base address of the data segment
//   DATA_SEG_SIZE   index of the last valid word in the segment
//   MAX_LOCK        max consecutive locked port-1 grants while port 0 waits
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   pN_req_i                   request from port N
//   pN_addr_i                  byte address
//   pN_wr_en_i                 1 = write, 0 = read
//   pN_wr_data_i               write data
//   pN_wr_strb_i               byte strobes, bit k enables data bits 8k+7:8k
//   p1_lock_i                  port 1 asks for back-to-back grants
//   pN_gnt_o                   request accepted this cycle
//   pN_rsp_valid_o             response for the port's previous transfer
//   pN_rsp_err_o               previous transfer was out of segment
//   pN_rd_data_o               registered read data (0 on error or write)
//   addr/wr_data/wr_strb/wr_en_dmem_ram_o   RAM drive
//   read_data_dmem_ram_i       RAM combinational read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter logic [31:0] DATA_SEG_BEGIN = 32'h0000_0000,
    parameter logic [31:0] DATA_SEG_SIZE  = 32'h0000_1FFF,
    parameter int unsigned MAX_LOCK       = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req_i,
    input  logic [31:0] p0_addr_i,
    input  logic        p0_wr_en_i,
    input  logic [31:0] p0_wr_data_i,
    input  logic [0:3]  p0_wr_strb_i,
    output logic        p0_gnt_o,
    output logic        p0_rsp_valid_o,
    output logic        p0_rsp_err_o,
    output logic [31:0] p0_rd_data_o,

    input  logic        p1_req_i,
    input  logic [31:0] p1_addr_i,
    input  logic        p1_wr_en_i,
    input  logic [31:0] p1_wr_data_i,
    input  logic [0:3]  p1_wr_strb_i,
    input  logic        p1_lock_i,
    output logic        p1_gnt_o,
    output logic        p1_rsp_valid_o,
    output logic        p1_rsp_err_o,
    output logic [31:0] p1_rd_data_o,

    output logic [31:0] addr_dmem_ram_o,
    output logic [31:0] wr_data_dmem_ram_o,
    output logic [0:3]  wr_strb_dmem_ram_o,
    output logic        wr_en_dmem_ram_o,
    input  logic [31:0] read_data_dmem_ram_i
);

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    // Word-granular segment check; the offset wraps at 32 bits so addresses
    // below the segment base land far above the top and are rejected.
    function automatic logic in_segment(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - DATA_SEG_BEGIN;
        return ({2'b00, off[31:2]} <= DATA_SEG_SIZE);
    endfunction

    // Arbitration state
    logic        last_gnt_q, last_gnt_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;

    // Response state
    logic        p0_rsp_valid_q, p0_rsp_valid_d;
    logic        p0_rsp_err_q,   p0_rsp_err_d;
    logic [31:0] p0_rd_data_q,   p0_rd_data_d;
    logic        p1_rsp_valid_q, p1_rsp_valid_d;
    logic        p1_rsp_err_q,   p1_rsp_err_d;
    logic [31:0] p1_rd_data_q,   p1_rd_data_d;

    // Combinational helpers
    logic        gnt0;
    logic        gnt1;
    logic        p0_in_range;
    logic        p1_in_range;
    logic        lock_win;

    assign p0_in_range = in_segment(p0_addr_i);
    assign p1_in_range = in_segment(p1_addr_i);

    // Port 1 keeps the RAM only while it held the last grant and its run
    // has not yet hit the bound.
    assign lock_win = last_gnt_q & p1_lock_i & (lock_cnt_q < MAX_LOCK_C);

    // Grant selection: single requester wins, contention is lock or round-robin.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (p0_req_i && p1_req_i) begin
            if (lock_win) begin
                gnt1 = 1'b1;
            end else if (last_gnt_q) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else if (p0_req_i) begin
            gnt0 = 1'b1;
        end else if (p1_req_i) begin
            gnt1 = 1'b1;
        end else begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign p0_gnt_o = gnt0;
    assign p1_gnt_o = gnt1;

    // RAM request mux: port 1 only when it is granted, otherwise port 0.
    always_comb begin
        addr_dmem_ram_o    = p0_addr_i;
        wr_data_dmem_ram_o = p0_wr_data_i;
        wr_strb_dmem_ram_o = p0_wr_strb_i;
        if (gnt1) begin
            addr_dmem_ram_o    = p1_addr_i;
            wr_data_dmem_ram_o = p1_wr_data_i;
            wr_strb_dmem_ram_o = p1_wr_strb_i;
        end else begin
            addr_dmem_ram_o    = p0_addr_i;
            wr_data_dmem_ram_o = p0_wr_data_i;
            wr_strb_dmem_ram_o = p0_wr_strb_i;
        end
    end

    // Out-of-segment writes are filtered here so they never touch the RAM.
    assign wr_en_dmem_ram_o = rst_n &
                              ((gnt0 & p0_wr_en_i & p0_in_range) |
                               (gnt1 & p1_wr_en_i & p1_in_range));

    // Next-state for last_gnt and the port-1 lock run counter.
    always_comb begin
        last_gnt_d = last_gnt_q;
        lock_cnt_d = lock_cnt_q;

        if (gnt0) begin
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
        end else begin
            last_gnt_d = last_gnt_q;
        end

        // The run only counts while port 0 is actually being held off.
        if (!p1_lock_i || !p0_req_i || gnt0) begin
            lock_cnt_d = 8'd0;
        end else if (gnt1 && (lock_cnt_q < MAX_LOCK_C)) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
    end

    // Next-state for the per-port response registers; rd_data holds when idle.
    always_comb begin
        p0_rsp_valid_d = gnt0;
        p0_rsp_err_d   = gnt0 & ~p0_in_range;
        p0_rd_data_d   = p0_rd_data_q;
        if (gnt0) begin
            if (!p0_wr_en_i && p0_in_range) begin
                p0_rd_data_d = read_data_dmem_ram_i;
            end else begin
                p0_rd_data_d = 32'h0000_0000;
            end
        end else begin
            p0_rd_data_d = p0_rd_data_q;
        end

        p1_rsp_valid_d = gnt1;
        p1_rsp_err_d   = gnt1 & ~p1_in_range;
        p1_rd_data_d   = p1_rd_data_q;
        if (gnt1) begin
            if (!p1_wr_en_i && p1_in_range) begin
                p1_rd_data_d = read_data_dmem_ram_i;
            end else begin
                p1_rd_data_d = 32'h0000_0000;
            end
        end else begin
            p1_rd_data_d = p1_rd_data_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q     <= 1'b1;
            lock_cnt_q     <= 8'd0;
            p0_rsp_valid_q <= 1'b0;
            p0_rsp_err_q   <= 1'b0;
            p0_rd_data_q   <= 32'h0000_0000;
            p1_rsp_valid_q <= 1'b0;
            p1_rsp_err_q   <= 1'b0;
            p1_rd_data_q   <= 32'h0000_0000;
        end else begin
            last_gnt_q     <= last_gnt_d;
            lock_cnt_q     <= lock_cnt_d;
            p0_rsp_valid_q <= p0_rsp_valid_d;
            p0_rsp_err_q   <= p0_rsp_err_d;
            p0_rd_data_q   <= p0_rd_data_d;
            p1_rsp_valid_q <= p1_rsp_valid_d;
            p1_rsp_err_q   <= p1_rsp_err_d;
            p1_rd_data_q   <= p1_rd_data_d;
        end
    end

    assign p0_rsp_valid_o = p0_rsp_valid_q;
    assign p0_rsp_err_o   = p0_rsp_err_q;
    assign p0_rd_data_o   = p0_rd_data_q;
    assign p1_rsp_valid_o = p1_rsp_valid_q;
    assign p1_rsp_err_o   = p1_rsp_err_q;
    assign p1_rd_data_o   = p1_rd_data_q;

    dmem_arbiter_checker #(
        .MAX_LOCK_C (MAX_LOCK_C)
    ) u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .p0_req     (p0_req_i),
        .p1_req     (p1_req_i),
        .ram_wr_en  (wr_en_dmem_ram_o),
        .lock_cnt   (lock_cnt_q),
        .rsp_valid0 (p0_rsp_valid_q),
        .rsp_valid1 (p1_rsp_valid_q)
    );

endmodule

// -----------------------------------------------------------------------------
// dmem_arbiter_checker
//
// Structural invariants of the arbiter: one grant per cycle, grants only to
// requesters, RAM writes only with a grant, bounded lock run, and at most one
// response per cycle.
// -----------------------------------------------------------------------------
module dmem_arbiter_checker #(
    parameter logic [7:0] MAX_LOCK_C = 8'd8
) (
    input logic       clk,
    input logic       rst_n,
    input logic       gnt0,
    input logic       gnt1,
    input logic       p0_req,
    input logic       p1_req,
    input logic       ram_wr_en,
    input logic [7:0] lock_cnt,
    input logic       rsp_valid0,
    input logic       rsp_valid1
);

    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(gnt0 && gnt1));

    a_gnt0_req: assert property (@(posedge clk) disable iff (!rst_n)
        gnt0 |-> p0_req);

    a_gnt1_req: assert property (@(posedge clk) disable iff (!rst_n)
        gnt1 |-> p1_req);

    a_wr_needs_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        ram_wr_en |-> (gnt0 || gnt1));

    a_lock_bound: assert property (@(posedge clk) disable iff (!rst_n)
        lock_cnt <= MAX_LOCK_C);

    a_one_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_valid0 && rsp_valid1));

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Table-driven bench for dmem_arbiter (MAX_LOCK = 3) with a behavioural
// byte-strobed RAM. Each vector is applied one cycle; grants and RAM write
// enable are checked in that cycle, and the response registers (which show
// the previous vector's transfer) are checked at the same time. A final
// hand-written sequence covers reset asserted during a grant cycle.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    typedef struct {
        logic        p0_req;
        logic [31:0] p0_addr;
        logic        p0_we;
        logic [31:0] p0_wd;
        logic [3:0]  p0_strb;
        logic        p1_req;
        logic [31:0] p1_addr;
        logic        p1_we;
        logic [31:0] p1_wd;
        logic [3:0]  p1_strb;
        logic        p1_lock;
        logic        g0;
        logic        g1;
        logic        we;
        logic        v0;
        logic        e0;
        logic [31:0] d0;
        logic        v1;
        logic        e1;
        logic [31:0] d1;
    } vec_t;

    localparam int NVEC = 30;

    localparam logic [31:0] Z    = 32'h0000_0000;
    localparam logic [31:0] A10  = 32'h0000_0010;
    localparam logic [31:0] A20  = 32'h0000_0020;
    localparam logic [31:0] AOOR = 32'h0000_8000;
    localparam logic [31:0] AO4  = 32'h0000_8004;
    localparam logic [31:0] ALST = 32'h0000_7FFC;
    localparam logic [31:0] DB   = 32'hDEAD_BEEF;
    localparam logic [31:0] BB   = 32'h11BB_33DD;
    localparam logic [3:0]  F    = 4'b1111;
    localparam logic [3:0]  N    = 4'b0000;

    logic        clk;
    logic        rst_n;
    logic        tb_init_n;

    logic        p0_req, p0_we, p0_gnt, p0_rsp_valid, p0_rsp_err;
    logic [31:0] p0_addr, p0_wd, p0_rd_data;
    logic [0:3]  p0_strb;
    logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rsp_valid, p1_rsp_err;
    logic [31:0] p1_addr, p1_wd, p1_rd_data;
    logic [0:3]  p1_strb;

    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [0:3]  ram_strb;
    logic        ram_we;

    logic [31:0] mem [0:8191];

    int n_cmp;
    int n_fail;

    vec_t vecs [NVEC];

    dmem_arbiter #(
        .DATA_SEG_BEGIN (32'h0000_0000),
        .DATA_SEG_SIZE  (32'h0000_1FFF),
        .MAX_LOCK       (3)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .p0_req_i             (p0_req),
        .p0_addr_i            (p0_addr),
        .p0_wr_en_i           (p0_we),
        .p0_wr_data_i         (p0_wd),
        .p0_wr_strb_i         (p0_strb),
        .p0_gnt_o             (p0_gnt),
        .p0_rsp_valid_o       (p0_rsp_valid),
        .p0_rsp_err_o         (p0_rsp_err),
        .p0_rd_data_o         (p0_rd_data),
        .p1_req_i             (p1_req),
        .p1_addr_i            (p1_addr),
        .p1_wr_en_i           (p1_we),
        .p1_wr_data_i         (p1_wd),
        .p1_wr_strb_i         (p1_strb),
        .p1_lock_i            (p1_lock),
        .p1_gnt_o             (p1_gnt),
        .p1_rsp_valid_o       (p1_rsp_valid),
        .p1_rsp_err_o         (p1_rsp_err),
        .p1_rd_data_o         (p1_rd_data),
        .addr_dmem_ram_o      (ram_addr),
        .wr_data_dmem_ram_o   (ram_wdata),
        .wr_strb_dmem_ram_o   (ram_strb),
        .wr_en_dmem_ram_o     (ram_we),
        .read_data_dmem_ram_i (ram_rdata)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: word-indexed by address bits 14:2, so an escaped
    // out-of-segment write to 0x8000 would show up at word 0.
    assign ram_rdata = mem[ram_addr[14:2]];

    // RAM write port with byte strobes; cleared while tb_init_n is low.
    always @(posedge clk) begin
        if (!tb_init_n) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 32'h0;
        end else if (ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (ram_strb[k]) mem[ram_addr[14:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
            end
        end
    end

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        p0_req  = v.p0_req;  p0_addr = v.p0_addr; p0_we = v.p0_we;
        p0_wd   = v.p0_wd;   p0_strb = v.p0_strb;
        p1_req  = v.p1_req;  p1_addr = v.p1_addr; p1_we = v.p1_we;
        p1_wd   = v.p1_wd;   p1_strb = v.p1_strb; p1_lock = v.p1_lock;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;

        //            p0: req  addr  we    wdata          strb  p1: req  addr  we    wdata          strb lock   g0    g1    we     v0    e0    d0   v1    e1    d1
        // single write then read on port 0
        vecs[0]  = '{1'b1, A10,  1'b1, DB,            F, 1'b0, Z,   1'b0, Z,             N, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z};
        vecs[1]  = '{1'b1, A10,  1'b0, Z,             F, 1'b0, Z,   1'b0, Z,             N, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, Z,  1'b0, 1'b0, Z};
        vecs[2]  = '{1'b0, Z,    1'b0, Z,             N, 1'b0, Z,   1'b0, Z,             N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, DB, 1'b0, 1'b0, Z};
        // byte strobes on port 1
        vecs[3]  = '{1'b0, Z,    1'b0, Z,             N, 1'b1, A20, 1'b1, 32'h11223344,  F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DB, 1'b0, 1'b0, Z};
        vecs[4]  = '{1'b0, Z,    1'b0, Z,             N, 1'b1, A20, 1'b1, 32'hAABBCCDD, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DB, 1'b1, 1'b0, Z};
        vecs[5]  = '{1'b0, Z,    1'b0, Z,             N, 1'b1, A20, 1'b0, Z,             F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, Z};
        vecs[6]  = '{1'b0, Z,    1'b0, Z,             N, 1'b0, Z,   1'b0, Z,             N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        // out-of-segment write, aliasing word 0 must stay zero, segment edges
        vecs[7]  = '{1'b1, AOOR, 1'b1, 32'hCAFEF00D,  F, 1'b0, Z,   1'b0, Z,             N, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DB, 1'b0, 1'b0, BB};
        vecs[8]  = '{1'b1, Z,    1'b0, Z,             F, 1'b0, Z,   1'b0, Z,             N, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, Z,  1'b0, 1'b0, BB};
        vecs[9]  = '{1'b1, AO4,  1'b0, Z,             F, 1'b0, Z,   1'b0, Z,             N, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, Z,  1'b0, 1'b0, BB};
        vecs[10] = '{1'b1, ALST, 1'b0, Z,             F, 1'b0, Z,   1'b0, Z,             N, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, Z,  1'b0, 1'b0, BB};
        // round-robin, no lock (last grant was port 0)
        vecs[11] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, Z,  1'b0, 1'b0, BB};
        vecs[12] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b1, 1'b0, BB};
        vecs[13] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, DB, 1'b0, 1'b0, BB};
        vecs[14] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        // lock with MAX_LOCK = 3: runs of three port-1 grants
        vecs[15] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, DB, 1'b0, 1'b0, BB};
        vecs[16] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        vecs[17] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        vecs[18] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        vecs[19] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, DB, 1'b0, 1'b0, BB};
        vecs[20] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        // port 0 idle: port 1 granted every cycle, run counter clears
        vecs[21] = '{1'b0, Z,    1'b0, Z,             N, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        vecs[22] = '{1'b0, Z,    1'b0, Z,             N, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        vecs[23] = '{1'b0, Z,    1'b0, Z,             N, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        vecs[24] = '{1'b0, Z,    1'b0, Z,             N, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        // contention resumes: a fresh run of three before port 0
        vecs[25] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        vecs[26] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        vecs[27] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        vecs[28] = '{1'b1, A10,  1'b0, Z,             F, 1'b1, A20, 1'b0, Z,             F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DB, 1'b1, 1'b0, BB};
        vecs[29] = '{1'b0, Z,    1'b0, Z,             N, 1'b0, Z,   1'b0, Z,             N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, DB, 1'b0, 1'b0, BB};

        drive(vecs[29]);
        rst_n = 1'b0;
        tb_init_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tb_init_n = 1'b1;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            #3;
            chk("gnt0",       i, {31'b0, p0_gnt},       {31'b0, vecs[i].g0});
            chk("gnt1",       i, {31'b0, p1_gnt},       {31'b0, vecs[i].g1});
            chk("ram_wr_en",  i, {31'b0, ram_we},       {31'b0, vecs[i].we});
            chk("rsp_valid0", i, {31'b0, p0_rsp_valid}, {31'b0, vecs[i].v0});
            chk("rsp_err0",   i, {31'b0, p0_rsp_err},   {31'b0, vecs[i].e0});
            chk("rd_data0",   i, p0_rd_data,            vecs[i].d0);
            chk("rsp_valid1", i, {31'b0, p1_rsp_valid}, {31'b0, vecs[i].v1});
            chk("rsp_err1",   i, {31'b0, p1_rsp_err},   {31'b0, vecs[i].e1});
            chk("rd_data1",   i, p1_rd_data,            vecs[i].d1);
        end

        // Reset asserted in the grant cycle of a port-1 read, with a port-0
        // write pending; last grant was port 0 so port 1 would win here.
        @(posedge clk);
        #1;
        p0_req = 1'b1; p0_addr = A10; p0_we = 1'b1; p0_wd = 32'h12345678; p0_strb = F;
        p1_req = 1'b1; p1_addr = A20; p1_we = 1'b0; p1_wd = Z; p1_strb = F; p1_lock = 1'b0;
        #1;
        chk("pre_rst_gnt1", 100, {31'b0, p1_gnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_gnt0",       101, {31'b0, p0_gnt},       32'd0);
        chk("rst_gnt1",       101, {31'b0, p1_gnt},       32'd0);
        chk("rst_wr_en",      101, {31'b0, ram_we},       32'd0);
        chk("rst_rd_data0",   101, p0_rd_data,            Z);
        chk("rst_rd_data1",   101, p1_rd_data,            Z);
        @(posedge clk);
        #3;
        chk("rst_rsp_valid0", 102, {31'b0, p0_rsp_valid}, 32'd0);
        chk("rst_rsp_valid1", 102, {31'b0, p1_rsp_valid}, 32'd0);
        chk("rst_wr_en2",     102, {31'b0, ram_we},       32'd0);
        // Release with both still requesting; port 0 now reads back its word.
        p0_we = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_gnt0",  103, {31'b0, p0_gnt},       32'd1);
        chk("post_rst_gnt1",  103, {31'b0, p1_gnt},       32'd0);
        @(posedge clk);
        #3;
        chk("rr_gnt1",        104, {31'b0, p1_gnt},       32'd1);
        chk("rr_gnt0",        104, {31'b0, p0_gnt},       32'd0);
        chk("post_rsp_v0",    104, {31'b0, p0_rsp_valid}, 32'd1);
        chk("post_rd0",       104, p0_rd_data,            DB);
        chk("post_rsp_v1",    104, {31'b0, p1_rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        #2;
        chk("post_rsp_v1b",   105, {31'b0, p1_rsp_valid}, 32'd1);
        chk("post_rd1",       105, p1_rd_data,            BB);
        chk("post_rsp_v0b",   105, {31'b0, p0_rsp_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
